fp_seq_divider: RTL and testbench

FP_SEQ_DIVIDER -- requirements
Module: fp_seq_divider

---
 rtl/fp_seq_divider.sv | 147 ++++++++++++++
 tb/tb_fp_seq_divider.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_seq_divider.sv
// Signed fixed-point sequential divider: restoring division, one quotient bit per clock,
// with sign restoration, saturation and divide-by-zero reporting on a valid/ready interface.
module fp_seq_divider #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic                  div_by_zero,
    output logic                  overflow
);

    localparam int N     = DATA_WIDTH + FRAC_BITS;
    localparam int CNT_W = $clog2(N);

    localparam logic [DATA_WIDTH-1:0] Q_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] Q_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [N-1:0] POS_LIMIT = {{(N-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [N-1:0] NEG_LIMIT = {{(N-DATA_WIDTH){1'b0}}, 1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                state_reg, state_next;
    logic [N-1:0]          work_reg;      // dividend bits shift out the top, quotient bits shift in
    logic [DATA_WIDTH-1:0] rem_reg;
    logic [DATA_WIDTH-1:0] divisor_reg;
    logic                  sign_reg;
    logic [CNT_W-1:0]      iter_reg;
    logic [DATA_WIDTH-1:0] quotient_reg;
    logic                  div_by_zero_reg;
    logic                  overflow_reg;

    logic                  accept;
    logic                  last_iter;
    logic                  b_zero;
    logic [DATA_WIDTH-1:0] a_mag;
    logic [DATA_WIDTH-1:0] b_mag;
    logic [DATA_WIDTH:0]   rem_shift;
    logic [DATA_WIDTH:0]   diff;
    logic                  q_bit;
    logic [DATA_WIDTH-1:0] rem_next;
    logic [N-1:0]          work_next;
    logic [DATA_WIDTH-1:0] sat_q;
    logic                  sat_ov;

    assign in_ready    = (state_reg == IDLE);
    assign out_valid   = (state_reg == DONE);
    assign quotient    = quotient_reg;
    assign div_by_zero = div_by_zero_reg;
    assign overflow    = overflow_reg;

    assign accept    = in_valid && (state_reg == IDLE);
    assign last_iter = (iter_reg == CNT_W'(N - 1));
    assign b_zero    = (divisor == '0);

    // Unsigned magnitudes: the most negative value maps to 2^(DATA_WIDTH-1) without wrapping
    assign a_mag = dividend[DATA_WIDTH-1] ? -dividend : dividend;
    assign b_mag = divisor[DATA_WIDTH-1]  ? -divisor  : divisor;

    // Restoring step; the top bit of the difference is the borrow
    assign rem_shift = {rem_reg, work_reg[N-1]};
    assign diff      = rem_shift - {1'b0, divisor_reg};
    assign q_bit     = ~diff[DATA_WIDTH];
    assign rem_next  = q_bit ? diff[DATA_WIDTH-1:0] : rem_shift[DATA_WIDTH-1:0];
    assign work_next = {work_reg[N-2:0], q_bit};

    always_comb begin
        sat_q  = '0;
        sat_ov = 1'b0;
        if (!sign_reg) begin
            if (work_next > POS_LIMIT) begin
                sat_q  = Q_MAX;
                sat_ov = 1'b1;
            end else begin
                sat_q = work_next[DATA_WIDTH-1:0];
            end
        end else begin
            if (work_next > NEG_LIMIT) begin
                sat_q  = Q_MIN;
                sat_ov = 1'b1;
            end else begin
                sat_q = -work_next[DATA_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid) state_next = b_zero ? DONE : CALC;
            CALC:    if (last_iter) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_reg        <= '0;
            rem_reg         <= '0;
            divisor_reg     <= '0;
            sign_reg        <= 1'b0;
            iter_reg        <= '0;
            quotient_reg    <= '0;
            div_by_zero_reg <= 1'b0;
            overflow_reg    <= 1'b0;
        end else begin
            if (accept) begin
                work_reg    <= {a_mag, {FRAC_BITS{1'b0}}};
                rem_reg     <= '0;
                divisor_reg <= b_mag;
                sign_reg    <= dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1];
                iter_reg    <= '0;
                if (b_zero) begin
                    quotient_reg    <= dividend[DATA_WIDTH-1] ? Q_MIN : Q_MAX;
                    div_by_zero_reg <= 1'b1;
                    overflow_reg    <= 1'b0;
                end
            end else if (state_reg == CALC) begin
                work_reg <= work_next;
                rem_reg  <= rem_next;
                iter_reg <= last_iter ? '0 : iter_reg + 1'b1;
                if (last_iter) begin
                    quotient_reg    <= sat_q;
                    overflow_reg    <= sat_ov;
                    div_by_zero_reg <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_seq_divider.sv
// Self-checking bench for fp_seq_divider: vector table, scoreboard queue,
// output hold under back-pressure and reset in the middle of a division.
module tb_fp_seq_divider;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic        div_by_zero;
    logic        overflow;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic        dz;
        logic        ov;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] q;
        logic        dz;
        logic        ov;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[14];

    fp_seq_divider #(.DATA_WIDTH(32), .FRAC_BITS(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .div_by_zero(div_by_zero),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: compare when the output handshake is about to happen
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_result", 32'(out_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("quotient", quotient, e.q);
                check("div_by_zero", 32'(div_by_zero), 32'(e.dz));
                check("overflow", 32'(overflow), 32'(e.ov));
                $display("[TB] result q=%h dz=%0b ov=%0b (expected q=%h dz=%0b ov=%0b)",
                         quotient, div_by_zero, overflow, e.q, e.dz, e.ov);
            end
        end
    end

    task automatic do_op(input vec_t v, input bit hold);
        int   lat;
        exp_t e;
        @(posedge clk);
        #2;
        check("in_ready_idle", 32'(in_ready), 32'd1);
        dividend = v.a;
        divisor  = v.b;
        in_valid = 1'b1;
        @(posedge clk);
        e.q = v.q; e.dz = v.dz; e.ov = v.ov;
        sb_q.push_back(e);
        #2;
        in_valid = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        lat = 0;
        while (lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
        end
        check("latency", 32'(lat), 32'(v.lat));
        if (!out_valid) begin
            void'(sb_q.pop_back());
            return;
        end
        if (hold) begin
            for (int i = 0; i < 10; i++) begin
                #1;
                in_valid = 1'($urandom_range(0, 1));
                dividend = $urandom;
                divisor  = $urandom;
                @(posedge clk);
                #1;
                check("hold_quotient", quotient, v.q);
                check("hold_out_valid", 32'(out_valid), 32'd1);
                check("hold_in_ready", 32'(in_ready), 32'd0);
            end
            in_valid = 1'b0;
        end
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post_handshake_out_valid", 32'(out_valid), 32'd0);
        check("post_handshake_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b0;
        $display("[TB] op a=%h b=%h latency=%0d", v.a, v.b, lat);
    endtask

    initial begin
        int pulses;
        vecs[0]  = '{32'h00018000, 32'h00008000, 32'h00030000, 1'b0, 1'b0, 48};
        vecs[1]  = '{32'h00010000, 32'h00030000, 32'h00005555, 1'b0, 1'b0, 48};
        vecs[2]  = '{32'hFFFF0000, 32'h00030000, 32'hFFFFAAAB, 1'b0, 1'b0, 48};
        vecs[3]  = '{32'hFFFF0000, 32'h00040000, 32'hFFFFC000, 1'b0, 1'b0, 48};
        vecs[4]  = '{32'h00050000, 32'h00000000, 32'h7FFFFFFF, 1'b1, 1'b0, 1};
        vecs[5]  = '{32'hFFFB0000, 32'h00000000, 32'h80000000, 1'b1, 1'b0, 1};
        vecs[6]  = '{32'h7FFF0000, 32'h00000100, 32'h7FFFFFFF, 1'b0, 1'b1, 48};
        vecs[7]  = '{32'h80000000, 32'h00008000, 32'h80000000, 1'b0, 1'b1, 48};
        vecs[8]  = '{32'h80000000, 32'h00010000, 32'h80000000, 1'b0, 1'b0, 48};
        vecs[9]  = '{32'h00020000, 32'hFFFF0000, 32'hFFFE0000, 1'b0, 1'b0, 48};
        vecs[10] = '{32'hFFFFFFFF, 32'h00030000, 32'h00000000, 1'b0, 1'b0, 48};
        vecs[11] = '{32'hFFFF8000, 32'hFFFF0000, 32'h00008000, 1'b0, 1'b0, 48};
        vecs[12] = '{32'h00000000, 32'h00000000, 32'h7FFFFFFF, 1'b1, 1'b0, 1};
        vecs[13] = '{32'h80000000, 32'hFFFF0000, 32'h7FFFFFFF, 1'b0, 1'b1, 48};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        #3;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_quotient", quotient, 32'd0);
        check("reset_div_by_zero", 32'(div_by_zero), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            do_op(vecs[i], 1'b0);
        end

        // Back-pressure: outputs hold while inputs toggle
        do_op(vecs[1], 1'b1);

        // Reset in the middle of CALC, after a divide-by-zero result left flags set
        do_op(vecs[4], 1'b0);
        @(posedge clk);
        #2;
        dividend = vecs[0].a;
        divisor  = vecs[0].b;
        in_valid = 1'b1;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        repeat (19) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_in_ready", 32'(in_ready), 32'd1);
        check("midreset_quotient", quotient, 32'd0);
        check("midreset_div_by_zero", 32'(div_by_zero), 32'd0);
        check("midreset_overflow", 32'(overflow), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) pulses++;
        end
        check("post_reset_pulses", 32'(pulses), 32'd0);
        do_op(vecs[2], 1'b0);

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
